game_board: RTL and testbench

GAME_BOARD -- requirements
Module: game_board

---
 rtl/game_board.sv | 187 ++++++++++++++++++
 tb/tb_game_board.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_board.sv
// ----------------------------------------------------------------------------
// game_board
//   Tic-tac-toe board controller. Holds nine 2-bit cells behind a single write
//   port, accepts moves only while in PLAY, checks for a win or tie one cycle
//   after every accepted move, and clears the board with a nine-cycle sweep
//   on newGame.
//
// Ports
//   ph1          in   clock, all state updates on rising edge
//   reset        in   synchronous active-high reset
//   newGame      in   start board-clear sweep (level-sampled)
//   addr[3:0]    in   cell address: 0-8 cell, 15 idle, 9-14 invalid
//   cellState    in   value to write: 00 EMPTY, 11 O, 10 X
//   gBoard[17:0] out  board image, cell i in bits [2i+1:2i]
//   gameIsDone   out  game finished (win or tie)
//   winner[1:0]  out  11 O win, 10 X win, 01 tie, 00 no result
//   moveCount    out  accepted moves, 0-9
//   ready        out  high only in PLAY (combinational from state)
//   writeAck     out  pulse: previous cycle's write stored
//   illegalWrite out  pulse: previous cycle's request rejected
// ----------------------------------------------------------------------------
module game_board (
   input  logic        ph1,
   input  logic        reset,
   input  logic        newGame,
   input  logic [3:0]  addr,
   input  logic [1:0]  cellState,
   output logic [17:0] gBoard,
   output logic        gameIsDone,
   output logic [1:0]  winner,
   output logic [3:0]  moveCount,
   output logic        ready,
   output logic        writeAck,
   output logic        illegalWrite
);

   typedef enum logic [1:0] {CLEAR, PLAY, CHECK, DONE} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [17:0] board_q, board_d;
   logic        done_q, done_d;
   logic [1:0]  win_q, win_d;
   logic [3:0]  moves_q, moves_d;
   logic        ack_q, ack_d;
   logic        ill_q, ill_d;

   // single board write port
   logic        wr_en;
   logic [3:0]  wr_idx;
   logic [1:0]  wr_val;

   logic        req;
   logic        accept;
   logic [1:0]  target;
   logic [8:0]  o_cells;
   logic [8:0]  x_cells;

   function automatic logic has_line(input logic [8:0] m);
      has_line = (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) |
                 (m[6] & m[7] & m[8]) | (m[0] & m[3] & m[6]) |
                 (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
                 (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
   endfunction

   // Cell lookup by scanning, so an out-of-range addr never forms an
   // out-of-bounds select; target stays 00 for addr 9-15.
   always_comb begin
      target  = '0;
      o_cells = '0;
      x_cells = '0;
      for (int unsigned i = 0; i < 9; i++) begin
         if (addr == i[3:0]) target = board_q[2*i +: 2];
         o_cells[i] = (board_q[2*i +: 2] == 2'b11);
         x_cells[i] = (board_q[2*i +: 2] == 2'b10);
      end
   end

   assign req    = (addr != 4'hF);
   assign accept = !newGame && (state_q == PLAY) && (addr <= 4'd8) &&
                   (target == 2'b00) && cellState[1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      win_d   = win_q;
      moves_d = moves_q;
      ack_d   = 1'b0;
      ill_d   = req && !accept;
      wr_en   = 1'b0;
      wr_idx  = cnt_q;
      wr_val  = '0;

      // newGame wins over every state action, including the sweep write
      if (newGame) begin
         state_d = CLEAR;
         cnt_d   = '0;
         done_d  = 1'b0;
         win_d   = '0;
         moves_d = '0;
      end else begin
         case (state_q)
            CLEAR: begin
               wr_en  = 1'b1;
               wr_idx = cnt_q;
               if (cnt_q == 4'd8) begin
                  state_d = PLAY;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            PLAY: begin
               if (accept) begin
                  wr_en   = 1'b1;
                  wr_idx  = addr;
                  wr_val  = cellState;
                  moves_d = moves_q + 4'd1;
                  ack_d   = 1'b1;
                  state_d = CHECK;
               end
            end
            CHECK: begin
               // O checked first so it wins if both lines ever coexist
               if (has_line(o_cells)) begin
                  win_d   = 2'b11;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else if (has_line(x_cells)) begin
                  win_d   = 2'b10;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else if (moves_q == 4'd9) begin
                  win_d   = 2'b01;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = PLAY;
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = PLAY;
            end
         endcase
      end

      board_d = board_q;
      for (int unsigned i = 0; i < 9; i++) begin
         if (wr_en && (wr_idx == i[3:0])) board_d[2*i +: 2] = wr_val;
      end
   end

   always_ff @(posedge ph1) begin
      if (reset) begin
         state_q <= PLAY;
         cnt_q   <= '0;
         board_q <= '0;
         done_q  <= 1'b0;
         win_q   <= '0;
         moves_q <= '0;
         ack_q   <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         board_q <= board_d;
         done_q  <= done_d;
         win_q   <= win_d;
         moves_q <= moves_d;
         ack_q   <= ack_d;
         ill_q   <= ill_d;
      end
   end

   assign gBoard       = board_q;
   assign gameIsDone   = done_q;
   assign winner       = win_q;
   assign moveCount    = moves_q;
   assign ready        = (state_q == PLAY);
   assign writeAck     = ack_q;
   assign illegalWrite = ill_q;

endmodule

// File: tb/tb_game_board.sv
// ----------------------------------------------------------------------------
// tb_game_board
//   Directed scenarios followed by a randomized run. Every cycle the outputs
//   are compared with a behavioural game model (cells array, remaining-clear
//   count, pending-check and done flags); directed steps add fixed-value
//   checks on top.
// ----------------------------------------------------------------------------
module tb_game_board;

   logic        ph1 = 1'b0;
   logic        reset, newGame;
   logic [3:0]  addr;
   logic [1:0]  cellState;
   logic [17:0] gBoard;
   logic        gameIsDone;
   logic [1:0]  winner;
   logic [3:0]  moveCount;
   logic        ready, writeAck, illegalWrite;

   game_board dut (
      .ph1          (ph1),
      .reset        (reset),
      .newGame      (newGame),
      .addr         (addr),
      .cellState    (cellState),
      .gBoard       (gBoard),
      .gameIsDone   (gameIsDone),
      .winner       (winner),
      .moveCount    (moveCount),
      .ready        (ready),
      .writeAck     (writeAck),
      .illegalWrite (illegalWrite)
   );

   always #5 ph1 = ~ph1;

   int nvec = 0;
   int nerr = 0;

   // behavioural model
   int mb [9];
   int m_clear_left;   // cells still to be swept, 0 when not clearing
   bit m_pending;      // a move was just stored and awaits evaluation
   bit m_done;
   int m_win;
   int m_moves;
   bit m_ack, m_ill;

   int L [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                    '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   function automatic bit m_line(int v);
      for (int k = 0; k < 8; k++)
         if (mb[L[k][0]] == v && mb[L[k][1]] == v && mb[L[k][2]] == v) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_playing();
      return (m_clear_left == 0) && !m_pending && !m_done;
   endfunction

   task automatic model_step(input bit rst, input bit ng, input int a, input int cs);
      bit req, ok;
      if (rst) begin
         for (int i = 0; i < 9; i++) mb[i] = 0;
         m_clear_left = 0; m_pending = 0; m_done = 0;
         m_win = 0; m_moves = 0; m_ack = 0; m_ill = 0;
         return;
      end
      req = (a != 15);
      ok  = !ng && m_playing() && a <= 8 && mb[a] == 0 && (cs == 3 || cs == 2);
      if (ng) begin
         m_clear_left = 9; m_pending = 0; m_done = 0; m_win = 0; m_moves = 0;
      end else if (m_clear_left > 0) begin
         mb[9 - m_clear_left] = 0;
         m_clear_left--;
      end else if (m_pending) begin
         m_pending = 0;
         if (m_line(3))         begin m_win = 3; m_done = 1; end
         else if (m_line(2))    begin m_win = 2; m_done = 1; end
         else if (m_moves == 9) begin m_win = 1; m_done = 1; end
      end else if (ok) begin
         mb[a] = cs;
         m_moves++;
         m_pending = 1;
      end
      m_ack = ok;
      m_ill = req && !ok;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      logic [17:0] eb;
      for (int i = 0; i < 9; i++) eb[2*i +: 2] = mb[i][1:0];
      chk("gBoard",       32'(gBoard),       32'(eb));
      chk("gameIsDone",   32'(gameIsDone),   32'(m_done));
      chk("winner",       32'(winner),       32'(m_win));
      chk("moveCount",    32'(moveCount),    32'(m_moves));
      chk("ready",        32'(ready),        32'(m_playing()));
      chk("writeAck",     32'(writeAck),     32'(m_ack));
      chk("illegalWrite", 32'(illegalWrite), 32'(m_ill));
   endtask

   // One clock: drive, let the edge happen, update model, compare 1 ns later.
   task automatic step(input bit rst, input bit ng, input int a, input int cs);
      reset     = rst;
      newGame   = ng;
      addr      = 4'(a);
      cellState = 2'(cs);
      @(posedge ph1);
      model_step(rst, ng, a, cs);
      #1;
      check_model();
   endtask

   task automatic idle();
      step(0, 0, 15, 0);
   endtask

   logic [17:0] saved;

   initial begin
      // reset state
      step(1, 0, 15, 0);
      chk("rst_board", 32'(gBoard), 32'd0);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_ack",   32'(writeAck), 32'd0);

      // single write of O to the centre
      step(0, 0, 4, 3);
      chk("r21_cell4", 32'(gBoard[9:8]), 32'h3);
      chk("r21_ack",   32'(writeAck), 32'd1);
      chk("r21_moves", 32'(moveCount), 32'd1);
      chk("r21_busy",  32'(ready), 32'd0);
      idle();
      chk("r21_ready", 32'(ready), 32'd1);
      chk("r21_ackoff", 32'(writeAck), 32'd0);

      // O wins on top row
      step(1, 0, 15, 0);
      step(0, 0, 0, 3); idle();
      step(0, 0, 3, 2); idle();
      step(0, 0, 1, 3); idle();
      step(0, 0, 4, 2); idle();
      step(0, 0, 2, 3);
      chk("r22_pre", 32'(gameIsDone), 32'd0);
      idle();
      chk("r22_done", 32'(gameIsDone), 32'd1);
      chk("r22_win",  32'(winner), 32'h3);
      saved = gBoard;
      step(0, 0, 5, 2);
      chk("r22_ill",   32'(illegalWrite), 32'd1);
      chk("r22_board", 32'(gBoard), 32'(saved));

      // rejected requests
      step(1, 0, 15, 0);
      step(0, 0, 0, 3); idle();
      step(0, 0, 0, 2);
      chk("r23_occ", 32'(illegalWrite), 32'd1);
      chk("r23_moves", 32'(moveCount), 32'd1);
      step(0, 0, 10, 3);
      chk("r23_addr10", 32'(illegalWrite), 32'd1);
      step(0, 0, 5, 2);
      chk("r23_ok", 32'(writeAck), 32'd1);
      step(0, 0, 6, 3);
      chk("r23_check", 32'(illegalWrite), 32'd1);
      chk("r23_moves2", 32'(moveCount), 32'd2);
      chk("r23_cell6", 32'(gBoard[13:12]), 32'd0);
      step(0, 0, 7, 1);
      chk("r23_cs01", 32'(illegalWrite), 32'd1);
      idle();
      chk("r23_idle", 32'(illegalWrite), 32'd0);

      // tie game
      step(1, 0, 15, 0);
      step(0, 0, 0, 3); idle();
      step(0, 0, 1, 2); idle();
      step(0, 0, 2, 3); idle();
      step(0, 0, 4, 2); idle();
      step(0, 0, 3, 3); idle();
      step(0, 0, 5, 2); idle();
      step(0, 0, 7, 3); idle();
      step(0, 0, 6, 2); idle();
      step(0, 0, 8, 3); idle();
      chk("r24_win",   32'(winner), 32'h1);
      chk("r24_done",  32'(gameIsDone), 32'd1);
      chk("r24_moves", 32'(moveCount), 32'd9);

      // newGame sweep from DONE
      step(0, 1, 15, 0);
      chk("r25_ready0", 32'(ready), 32'd0);
      chk("r25_win0",   32'(winner), 32'd0);
      for (int i = 0; i < 8; i++) begin
         idle();
         chk("r25_sweep", 32'(ready), 32'd0);
      end
      idle();
      chk("r25_ready", 32'(ready), 32'd1);
      chk("r25_board", 32'(gBoard), 32'd0);

      // restart mid-sweep
      step(0, 0, 4, 2); idle();
      step(0, 1, 15, 0);
      for (int i = 0; i < 5; i++) idle();
      step(0, 1, 3, 3);
      chk("r25_ngreq", 32'(illegalWrite), 32'd1);
      for (int i = 0; i < 8; i++) begin
         idle();
         chk("r25_restart", 32'(ready), 32'd0);
      end
      idle();
      chk("r25_ready2", 32'(ready), 32'd1);

      // reset mid-clear with a pending write
      step(0, 0, 0, 3); idle();
      step(0, 1, 15, 0);
      idle(); idle(); idle();
      step(1, 0, 2, 3);
      chk("r26_board", 32'(gBoard), 32'd0);
      chk("r26_ready", 32'(ready), 32'd1);
      chk("r26_ill",   32'(illegalWrite), 32'd0);
      chk("r26_ack",   32'(writeAck), 32'd0);

      // randomized play
      for (int n = 0; n < 1500; n++) begin
         bit rst, ng;
         int a, cs;
         rst = ($urandom_range(0, 199) == 0);
         ng  = ($urandom_range(0, 39) == 0);
         a   = ($urandom_range(0, 3) == 0) ? 15 : int'($urandom_range(0, 15));
         if (a < 9 && $urandom_range(0, 1) == 1) a = int'($urandom_range(0, 8));
         cs  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 1))
                                           : int'($urandom_range(2, 3));
         step(rst, ng, a, cs);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
